dmem_responder: RTL and testbench

Data-memory responder: the target end of the load/store address path driven by the memory-access stage. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, and performs the access. It then returns a response over a second valid/ready handshake that is held until the consumer takes it. It sits between the MA/MO pipeline stages and a synchronous word-addressed RAM that lives inside this block.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the load/store address path. Accepts one request at a time
//   over a valid/ready handshake, waits WAIT_CYCLES cycles, performs the access
//   on an internal word-addressed RAM and holds the response until the
//   consumer takes it.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   : addresses >= DEPTH are rejected (store suppressed, rdata 0,
//               rsp_err 1); in-range accesses report rsp_err 0.
//   undefined : addresses wrap modulo DEPTH; rsp_err is tied 0.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (IDLE)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   word address
//   req_wdata  in   store data
//   rsp_valid  out  response present (RESP)
//   rsp_ready  in   consumer takes the response
//   rsp_rdata  out  load data, or the written value for a store
//   rsp_err    out  access rejected by the bounds check
//   busy       out  transaction accepted and response not yet taken
module dmem_responder #(
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] ram [DEPTH];
    logic              ram_we;
    logic [31:0]       idx_full;
    logic [IDX_W-1:0]  ram_idx;

    // Index is computed at 32 bits so a DEPTH equal to 2^ADDR_W does not
    // collapse to a zero modulus.
    assign idx_full = 32'(addr_q) % DEPTH;
    assign ram_idx  = IDX_W'(idx_full);

`ifdef DMEM_BOUNDS_CHECK_EN
    logic err_q, err_d;
    logic in_range;
    assign in_range = (32'(addr_q) < DEPTH);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ram_we  = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge: the RAM and the response register update together.
                    state_d = S_RESP;
`ifdef DMEM_BOUNDS_CHECK_EN
                    if (!in_range) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        if (we_q) begin
                            ram_we  = 1'b1;
                            rdata_d = wdata_q;
                        end else begin
                            rdata_d = ram[ram_idx];
                        end
                    end
`else
                    if (we_q) begin
                        ram_we  = 1'b1;
                        rdata_d = wdata_q;
                    end else begin
                        rdata_d = ram[ram_idx];
                    end
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_BOUNDS_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_BOUNDS_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // RAM contents survive reset, but a reset on the access edge cancels the store.
    always_ff @(posedge clk) begin
        if (rst && ram_we) begin
            ram[ram_idx] <= wdata_q;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;
`ifdef DMEM_BOUNDS_CHECK_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances with WAIT_CYCLES 0, 1 and 3
// (array index 0, 1, 2), a directed table, hand-written reset/spacing
// sequences and randomized transactions against a flat-array memory model.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [11:0] req_addr  [3];
    logic [11:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [11:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] mdl   [3][1024];
    bit          mdl_w [3][1024];

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [11:0] wdata;
        int          hold;
        logic [11:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [6];

    dmem_responder #(.DATA_W(12), .ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.DATA_W(12), .ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    dmem_responder #(.DATA_W(12), .ADDR_W(12), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wc_of(input int k);
        if (k == 0) return 0;
        if (k == 1) return 1;
        return 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: one access against a flat array, from the address rules.
    function automatic void model_access(input int k, input bit we, input logic [11:0] addr,
                                         input logic [11:0] wd, output logic [11:0] rd,
                                         output bit er, output bit known);
        int idx;
`ifdef DMEM_BOUNDS_CHECK_EN
        if (int'(addr) >= 1024) begin
            rd = '0; er = 1'b1; known = 1'b1;
            return;
        end
`endif
        idx = int'(addr) % 1024;
        er  = 1'b0;
        if (we) begin
            mdl[k][idx]   = wd;
            mdl_w[k][idx] = 1'b1;
            rd    = wd;
            known = 1'b1;
        end else begin
            rd    = mdl[k][idx];
            known = mdl_w[k][idx];
        end
    endfunction

    task automatic scramble(input int k);
        req_valid[k] = 1'($urandom_range(0, 1));
        req_we[k]    = 1'($urandom_range(0, 1));
        req_addr[k]  = 12'($urandom);
        req_wdata[k] = 12'($urandom);
    endtask

    task automatic do_txn(input int k, input bit we, input logic [11:0] addr,
                          input logic [11:0] wdata, input int hold,
                          output logic [11:0] rd, output logic er);
        int          e;
        logic [11:0] exp_rd;
        bit          exp_er;
        bit          known;
        model_access(k, we, addr, wdata, exp_rd, exp_er, known);
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        rsp_ready[k] = 1'b0;
        @(negedge clk);
        e = 0;
        scramble(k);
        while (!rsp_valid[k] && e < 40) begin
            check("wait_req_ready_low", 32'(req_ready[k]), 32'd0);
            check("wait_busy", 32'(busy[k]), 32'd1);
            @(negedge clk);
            e++;
            scramble(k);
        end
        check("rsp_latency", 32'(e), 32'(wc_of(k) + 1));
        rd = rsp_rdata[k];
        er = rsp_err[k];
        if (known) check("rsp_rdata", 32'(rd), 32'(exp_rd));
        check("rsp_err", 32'(er), 32'(exp_er));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            scramble(k);
            check("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
            check("hold_req_ready", 32'(req_ready[k]), 32'd0);
            check("hold_rdata_stable", 32'(rsp_rdata[k]), 32'(rd));
            check("hold_err_stable", 32'(rsp_err[k]), 32'(er));
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        check("post_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        check("post_req_ready", 32'(req_ready[k]), 32'd1);
        check("post_busy", 32'(busy[k]), 32'd0);
        rsp_ready[k] = 1'b0;
    endtask

    task automatic spacing_test(input int k);
        int  gap;
        int  accepts;
        bit  started;
        gap = 0; accepts = 0; started = 1'b0;
        @(negedge clk);
        rsp_ready[k] = 1'b1;
        req_we[k]    = 1'b0;
        req_addr[k]  = 12'h005;
        req_valid[k] = 1'b1;
        for (int c = 0; c < (wc_of(k) + 3) * 4; c++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                if (started) check("accept_gap", 32'(gap), 32'(wc_of(k) + 2));
                started = 1'b1;
                gap = 0;
                accepts++;
            end else begin
                gap++;
            end
        end
        req_valid[k] = 1'b0;
        for (int c = 0; c < 20 && busy[k]; c++) @(negedge clk);
        check("spacing_drained", 32'(busy[k]), 32'd0);
        check("spacing_accepts", 32'(accepts >= 3), 32'd1);
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        logic [11:0] rd;
        logic        er;
        bit          we;
        logic [11:0] addr;

        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k]  = '0;   req_wdata[k] = '0;
            rsp_ready[k] = 1'b0;
            for (int i = 0; i < 1024; i++) mdl_w[k][i] = 1'b0;
        end

        tbl[0] = '{we: 1'b1, addr: 12'h005, wdata: 12'hA5C, hold: 0, exp_rd: 12'hA5C, exp_err: 1'b0};
        tbl[1] = '{we: 1'b0, addr: 12'h005, wdata: 12'h000, hold: 6, exp_rd: 12'hA5C, exp_err: 1'b0};
        tbl[2] = '{we: 1'b1, addr: 12'h001, wdata: 12'h0B1, hold: 1, exp_rd: 12'h0B1, exp_err: 1'b0};
`ifdef DMEM_BOUNDS_CHECK_EN
        tbl[3] = '{we: 1'b1, addr: 12'h401, wdata: 12'h7FF, hold: 2, exp_rd: 12'h000, exp_err: 1'b1};
        tbl[4] = '{we: 1'b0, addr: 12'h001, wdata: 12'h000, hold: 0, exp_rd: 12'h0B1, exp_err: 1'b0};
        tbl[5] = '{we: 1'b0, addr: 12'h401, wdata: 12'h000, hold: 0, exp_rd: 12'h000, exp_err: 1'b1};
`else
        tbl[3] = '{we: 1'b1, addr: 12'h401, wdata: 12'h7FF, hold: 2, exp_rd: 12'h7FF, exp_err: 1'b0};
        tbl[4] = '{we: 1'b0, addr: 12'h001, wdata: 12'h000, hold: 0, exp_rd: 12'h7FF, exp_err: 1'b0};
        tbl[5] = '{we: 1'b0, addr: 12'h401, wdata: 12'h000, hold: 0, exp_rd: 12'h7FF, exp_err: 1'b0};
`endif

        // Reset values, checked in the first cycle after release.
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_req_ready", 32'(req_ready[k]), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            check("rst_rsp_rdata", 32'(rsp_rdata[k]), 32'd0);
            check("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
            check("rst_busy", 32'(busy[k]), 32'd0);
        end

        // Directed table on the WAIT_CYCLES=1 instance.
        for (int i = 0; i < 6; i++) begin
            do_txn(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rd, er);
            check("tbl_rdata", 32'(rd), 32'(tbl[i].exp_rd));
            check("tbl_err", 32'(er), 32'(tbl[i].exp_err));
        end

        // Reset on the access edge of a store abandons it.
        do_txn(1, 1'b1, 12'h010, 12'h777, 0, rd, er);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1;
        req_addr[1]  = 12'h010; req_wdata[1] = 12'h123;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_req_ready", 32'(req_ready[1]), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("abort_rdata", 32'(rsp_rdata[1]), 32'd0);
        check("abort_err", 32'(rsp_err[1]), 32'd0);
        check("abort_busy", 32'(busy[1]), 32'd0);
        do_txn(1, 1'b0, 12'h010, 12'h000, 0, rd, er);
        check("abort_store_dropped", 32'(rd), 32'h777);

        // Back-to-back spacing for each wait setting.
        for (int k = 0; k < 3; k++) spacing_test(k);

        // Randomized traffic with aliasing and out-of-range addresses.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 30; t++) begin
                we   = 1'($urandom_range(0, 1));
                addr = 12'($urandom_range(0, 7) + 1024 * $urandom_range(0, 3));
                do_txn(k, we, addr, 12'($urandom), int'($urandom_range(0, 3)), rd, er);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
